// File: rtl/count_ones_accumulator.sv
// Per-packet popcount accumulator: sums the high bits of every accepted beat and
// presents total, beat count and overflow on a registered valid/ready output.
module count_ones_accumulator #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_BEATS   = 16,
  parameter int unsigned COUNT_WIDTH = $clog2(WIDTH * MAX_BEATS + 1),
  parameter int unsigned BEATS_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [WIDTH-1:0]       input_data,
  input  logic                   input_last,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [COUNT_WIDTH-1:0] output_count,
  output logic [BEATS_WIDTH-1:0] output_beats,
  output logic                   output_overflow
);

  localparam int unsigned POP_WIDTH = $clog2(WIDTH + 1);
  localparam logic [BEATS_WIDTH-1:0] MAX_BEATS_V = BEATS_WIDTH'(MAX_BEATS);

  logic [COUNT_WIDTH-1:0] r_acc;
  logic [BEATS_WIDTH-1:0] r_beats;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic [COUNT_WIDTH-1:0] r_out_count;
  logic [BEATS_WIDTH-1:0] r_out_beats;
  logic                   r_out_ovf;

  logic [POP_WIDTH-1:0]   w_pop;
  logic                   w_accept;
  logic                   w_out_xfer;
  logic                   w_room;
  logic [COUNT_WIDTH-1:0] w_acc_next;
  logic [BEATS_WIDTH-1:0] w_beats_next;
  logic                   w_ovf_next;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + POP_WIDTH'(input_data[i]);
    end
  end

  assign input_ready = !r_out_valid || output_ready;
  assign w_accept    = input_valid && input_ready;
  assign w_out_xfer  = r_out_valid && output_ready;

  // Beats beyond MAX_BEATS are dropped from the sum and only raise the sticky flag.
  assign w_room       = (r_beats < MAX_BEATS_V);
  assign w_acc_next   = w_room ? (r_acc + COUNT_WIDTH'(w_pop)) : r_acc;
  assign w_beats_next = w_room ? (r_beats + BEATS_WIDTH'(1)) : r_beats;
  assign w_ovf_next   = r_ovf || !w_room;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (input_last) begin
          r_out_count <= w_acc_next;
          r_out_beats <= w_beats_next;
          r_out_ovf   <= w_ovf_next;
          r_acc       <= '0;
          r_beats     <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc       <= w_acc_next;
          r_beats     <= w_beats_next;
          r_ovf       <= w_ovf_next;
        end
      end
      // A new result wins over a drain in the same cycle, keeping valid high.
      if (w_accept && input_last) begin
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign output_valid    = r_out_valid;
  assign output_count    = r_out_count;
  assign output_beats    = r_out_beats;
  assign output_overflow = r_out_ovf;

endmodule
